cpu_core_param: RTL and testbench

//  Parametrised successor to the 16-bit single-cycle CPU top: register file, ALU, flag register and

---
 rtl/cpu_core_param.sv | 192 +++++++++++++++++++
 tb/tb_cpu_core_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_param.sv
// Parametrised two-cycle CPU core: register file, ALU, registered flags and a control FSM.
// Instructions are accepted over a valid/ready handshake in IDLE, computed in EXEC and
// committed in WB. A combinational debug port exposes any register.
module cpu_core_param #(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 16,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic              instr_imm_sel,
    input  logic [REG_AW-1:0] instr_dst,
    input  logic [REG_AW-1:0] instr_src,
    input  logic [7:0]        instr_imm,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic [4:0]        flags,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_CMP  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_MOV  = 4'd7;
    localparam logic [3:0] OP_LSH  = 4'd8;
    localparam logic [3:0] OP_LUI  = 4'd9;

    // Flag bit positions inside {N,Z,F,L,C}
    localparam int FL_C = 0;
    localparam int FL_L = 1;
    localparam int FL_F = 2;
    localparam int FL_Z = 3;
    localparam int FL_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t             state_r;
    logic [3:0]         op_r;
    logic [REG_AW-1:0]  dst_r;
    logic [7:0]         imm_r;
    logic [DATA_W-1:0]  a_r;
    logic [DATA_W-1:0]  b_r;
    logic [DATA_W-1:0]  result_r;
    logic [4:0]         flags_r;
    logic               done_r;
    logic [DATA_W-1:0]  regs_r [NUM_REGS];

    logic [DATA_W-1:0]  op_b_s;
    logic [DATA_W-1:0]  alu_res_s;
    logic [4:0]         alu_flags_s;
    logic [DATA_W:0]    sum_s;
    logic [DATA_W:0]    diff_s;
    logic               wr_en_s;

    // Sign-extend the 8-bit immediate to the datapath width
    function automatic logic [DATA_W-1:0] sext_imm(input logic [7:0] imm);
        return {{(DATA_W-8){imm[7]}}, imm};
    endfunction

    assign instr_ready = (state_r == ST_IDLE);
    assign result      = result_r;
    assign done        = done_r;
    assign flags       = flags_r;
    assign dbg_data    = regs_r[dbg_sel];

    // Second operand selection at accept time: sign-extended immediate or register
    always_comb begin
        op_b_s = '0;
        if (instr_imm_sel) begin
            op_b_s = sext_imm(instr_imm);
        end else begin
            op_b_s = regs_r[instr_src];
        end
    end

    // Register write is suppressed for CMP and the NOP encodings
    always_comb begin
        wr_en_s = 1'b0;
        if ((op_r <= OP_LUI) && (op_r != OP_CMP)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // ALU on the latched operands; untouched flag bits and NOP results hold their value
    always_comb begin
        alu_res_s   = result_r;
        alu_flags_s = flags_r;
        sum_s       = {1'b0, a_r} + {1'b0, b_r} +
                      {{DATA_W{1'b0}}, ((op_r == OP_ADDC) ? flags_r[FL_C] : 1'b0)};
        diff_s      = {1'b0, a_r} - {1'b0, b_r};
        case (op_r)
            OP_ADD, OP_ADDC: begin
                alu_res_s         = sum_s[DATA_W-1:0];
                alu_flags_s[FL_C] = sum_s[DATA_W];
                alu_flags_s[FL_F] = (a_r[MSB] == b_r[MSB]) && (sum_s[MSB] != a_r[MSB]);
                alu_flags_s[FL_Z] = (sum_s[DATA_W-1:0] == {DATA_W{1'b0}});
            end
            OP_SUB: begin
                alu_res_s         = diff_s[DATA_W-1:0];
                alu_flags_s[FL_C] = diff_s[DATA_W];
                alu_flags_s[FL_F] = (a_r[MSB] != b_r[MSB]) && (diff_s[MSB] != a_r[MSB]);
                alu_flags_s[FL_Z] = (diff_s[DATA_W-1:0] == {DATA_W{1'b0}});
            end
            OP_CMP: begin
                alu_res_s         = diff_s[DATA_W-1:0];
                alu_flags_s[FL_Z] = (a_r == b_r);
                alu_flags_s[FL_L] = (a_r < b_r);
                alu_flags_s[FL_N] = ($signed(a_r) < $signed(b_r));
            end
            OP_AND:  alu_res_s = a_r & b_r;
            OP_OR:   alu_res_s = a_r | b_r;
            OP_XOR:  alu_res_s = a_r ^ b_r;
            OP_MOV:  alu_res_s = b_r;
            OP_LSH:  alu_res_s = a_r << b_r[SH_W-1:0];
            OP_LUI: begin
                alu_res_s       = '0;
                alu_res_s[15:0] = {imm_r, a_r[7:0]};
            end
            default: begin
                alu_res_s   = result_r;
                alu_flags_s = flags_r;
            end
        endcase
    end

    // Control FSM: latch on accept, register ALU outputs in EXEC, commit in WB
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            op_r     <= 4'd0;
            dst_r    <= '0;
            imm_r    <= 8'd0;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            flags_r  <= 5'd0;
            done_r   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (instr_valid) begin
                        op_r    <= instr_op;
                        dst_r   <= instr_dst;
                        imm_r   <= instr_imm;
                        a_r     <= regs_r[instr_dst];
                        b_r     <= op_b_s;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_r <= alu_res_s;
                    flags_r  <= alu_flags_s;
                    done_r   <= 1'b1;
                    state_r  <= ST_WB;
                end
                ST_WB: begin
                    done_r <= 1'b0;
                    if (wr_en_s) begin
                        regs_r[dst_r] <= result_r;
                    end
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param: a 16x16 instance driven from a vector table plus
// hand-written reset and back-to-back sequences, and a 32x32 instance for wide ops.
module tb_cpu_core_param;

    logic        clk;
    logic        rst;

    logic        a_valid, a_ready, a_sel, a_done;
    logic [3:0]  a_op, a_dst, a_src, a_dbg_sel;
    logic [7:0]  a_imm;
    logic [15:0] a_result, a_dbg_data;
    logic [4:0]  a_flags;

    logic        b_valid, b_ready, b_sel, b_done;
    logic [3:0]  b_op;
    logic [4:0]  b_dst, b_src, b_dbg_sel;
    logic [7:0]  b_imm;
    logic [31:0] b_result, b_dbg_data;
    logic [4:0]  b_flags;

    int n_chk;
    int n_fail;

    cpu_core_param dut_a (
        .clk(clk), .rst(rst),
        .instr_valid(a_valid), .instr_ready(a_ready), .instr_op(a_op),
        .instr_imm_sel(a_sel), .instr_dst(a_dst), .instr_src(a_src), .instr_imm(a_imm),
        .result(a_result), .done(a_done), .flags(a_flags),
        .dbg_sel(a_dbg_sel), .dbg_data(a_dbg_data)
    );

    cpu_core_param #(.DATA_W(32), .NUM_REGS(32)) dut_b (
        .clk(clk), .rst(rst),
        .instr_valid(b_valid), .instr_ready(b_ready), .instr_op(b_op),
        .instr_imm_sel(b_sel), .instr_dst(b_dst), .instr_src(b_src), .instr_imm(b_imm),
        .result(b_result), .done(b_done), .flags(b_flags),
        .dbg_sel(b_dbg_sel), .dbg_data(b_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        sel;
        logic [3:0]  dst;
        logic [3:0]  src;
        logic [7:0]  imm;
        logic [15:0] exp_reg;
        logic [4:0]  exp_flags;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read a register through the debug port; call a little after a clock edge
    task automatic rd(input bit which_a, input int idx, output logic [31:0] v);
        if (which_a) a_dbg_sel = 4'(idx);
        else         b_dbg_sel = 5'(idx);
        #1;
        v = which_a ? {16'h0000, a_dbg_data} : b_dbg_data;
    endtask

    // Issue one instruction from IDLE and wait for its write-back; leaves the core in IDLE
    task automatic issue(input bit which_a, input logic [3:0] op, input logic sel,
                         input int dst, input int src, input logic [7:0] imm);
        int  n;
        bit  seen;
        check("ready_idle", which_a ? a_ready : b_ready, 32'd1);
        if (which_a) begin
            a_op = op; a_sel = sel; a_dst = 4'(dst); a_src = 4'(src); a_imm = imm; a_valid = 1'b1;
        end else begin
            b_op = op; b_sel = sel; b_dst = 5'(dst); b_src = 5'(src); b_imm = imm; b_valid = 1'b1;
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < 6 && !seen) begin
            @(negedge clk);
            n++;
            if (which_a ? a_done : b_done) seen = 1'b1;
        end
        check("done_latency", 32'(n), 32'd2);
        @(posedge clk); #1;
        check("done_single", which_a ? a_done : b_done, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        logic [15:0] last_res;
        int          acc;
        int          pulses;

        n_chk = 0; n_fail = 0;
        rst = 1'b0;
        a_valid = 1'b0; a_op = 4'd0; a_sel = 1'b0; a_dst = 4'd0; a_src = 4'd0; a_imm = 8'd0; a_dbg_sel = 4'd0;
        b_valid = 1'b0; b_op = 4'd0; b_sel = 1'b0; b_dst = 5'd0; b_src = 5'd0; b_imm = 8'd0; b_dbg_sel = 5'd0;

        //                op     sel   dst   src   imm     reg       flags {N,Z,F,L,C}
        vecs[0]  = '{4'd7,  1'b1, 4'd2, 4'd0, 8'h7F, 16'h007F, 5'b00000};
        vecs[1]  = '{4'd0,  1'b0, 4'd2, 4'd2, 8'h00, 16'h00FE, 5'b00000};
        vecs[2]  = '{4'd7,  1'b1, 4'd3, 4'd0, 8'hFF, 16'hFFFF, 5'b00000};
        vecs[3]  = '{4'd0,  1'b1, 4'd3, 4'd0, 8'h01, 16'h0000, 5'b01001};
        vecs[4]  = '{4'd7,  1'b1, 4'd4, 4'd0, 8'h7F, 16'h007F, 5'b01001};
        vecs[5]  = '{4'd9,  1'b1, 4'd4, 4'd0, 8'h7F, 16'h7F7F, 5'b01001};
        vecs[6]  = '{4'd0,  1'b0, 4'd4, 4'd4, 8'h00, 16'hFEFE, 5'b00100};
        vecs[7]  = '{4'd1,  1'b1, 4'd5, 4'd0, 8'h00, 16'h0000, 5'b01000};
        vecs[8]  = '{4'd7,  1'b1, 4'd6, 4'd0, 8'hFF, 16'hFFFF, 5'b01000};
        vecs[9]  = '{4'd3,  1'b1, 4'd6, 4'd0, 8'h01, 16'hFFFF, 5'b10000};
        vecs[10] = '{4'd2,  1'b1, 4'd6, 4'd0, 8'h01, 16'hFFFE, 5'b10000};
        vecs[11] = '{4'd2,  1'b1, 4'd7, 4'd0, 8'h01, 16'hFFFF, 5'b10001};
        vecs[12] = '{4'd4,  1'b0, 4'd6, 4'd2, 8'h00, 16'h00FE, 5'b10001};
        vecs[13] = '{4'd5,  1'b0, 4'd3, 4'd4, 8'h00, 16'hFEFE, 5'b10001};
        vecs[14] = '{4'd6,  1'b0, 4'd2, 4'd2, 8'h00, 16'h0000, 5'b10001};
        vecs[15] = '{4'd12, 1'b1, 4'd2, 4'd0, 8'h55, 16'h0000, 5'b10001};
        vecs[16] = '{4'd2,  1'b1, 4'd2, 4'd0, 8'h80, 16'h0080, 5'b10001};
        vecs[17] = '{4'd3,  1'b0, 4'd2, 4'd2, 8'h00, 16'h0080, 5'b01001};
        vecs[18] = '{4'd1,  1'b1, 4'd5, 4'd0, 8'h01, 16'h0002, 5'b00000};
        vecs[19] = '{4'd8,  1'b1, 4'd6, 4'd0, 8'h04, 16'h0FE0, 5'b00000};
        vecs[20] = '{4'd7,  1'b1, 4'd9, 4'd0, 8'h01, 16'h0001, 5'b00000};
        vecs[21] = '{4'd8,  1'b1, 4'd9, 4'd0, 8'h0F, 16'h8000, 5'b00000};
        vecs[22] = '{4'd2,  1'b1, 4'd9, 4'd0, 8'h01, 16'h7FFF, 5'b00100};
        vecs[23] = '{4'd8,  1'b1, 4'd9, 4'd0, 8'h11, 16'hFFFE, 5'b00100};
        vecs[24] = '{4'd15, 1'b1, 4'd9, 4'd0, 8'h33, 16'hFFFE, 5'b00100};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("rst_ready", a_ready, 32'd1);
        check("rst_done", a_done, 32'd0);
        check("rst_flags", a_flags, 32'd0);
        check("rst_result", a_result, 32'd0);
        check("rst_ready_b", b_ready, 32'd1);

        // Reset in the middle of EXEC discards the in-flight ADD
        issue(1'b1, 4'd7, 1'b1, 1, 0, 8'h09);
        rd(1'b1, 1, v);
        check("pre_r1", v, 32'h0009);
        a_op = 4'd0; a_sel = 1'b1; a_dst = 4'd1; a_imm = 8'h05; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready", a_ready, 32'd1);
        check("midrst_flags", a_flags, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (a_done) pulses++;
        end
        check("midrst_no_done", 32'(pulses), 32'd0);
        @(posedge clk); #1;
        rd(1'b1, 1, v);
        check("midrst_r1", v, 32'h0000);
        check("midrst_result", a_result, 32'h0000);

        // Table-driven instruction vectors
        last_res = 16'h0000;
        for (int i = 0; i < NV; i++) begin
            issue(1'b1, vecs[i].op, vecs[i].sel, int'(vecs[i].dst), int'(vecs[i].src), vecs[i].imm);
            rd(1'b1, int'(vecs[i].dst), v);
            check($sformatf("vec%0d_reg", i), v, {16'h0000, vecs[i].exp_reg});
            check($sformatf("vec%0d_flags", i), a_flags, {27'd0, vecs[i].exp_flags});
            if (vecs[i].op >= 4'd10) begin
                check($sformatf("vec%0d_res_hold", i), a_result, {16'h0000, last_res});
            end else if (vecs[i].op != 4'd3) begin
                check($sformatf("vec%0d_res", i), a_result, {16'h0000, vecs[i].exp_reg});
                last_res = vecs[i].exp_reg;
            end else begin
                last_res = a_result;
            end
        end

        // instr_valid held high for 10 cycles with a different MOV each cycle
        a_dbg_sel = 4'd8;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            a_valid = 1'b1; a_op = 4'd7; a_sel = 1'b1; a_dst = 4'd8; a_imm = 8'(8'h10 + i);
            @(negedge clk);
            check($sformatf("t5_ready%0d", i), a_ready, 32'((i % 3) == 0));
            check($sformatf("t5_done%0d", i), a_done, 32'((i % 3) == 2));
            check($sformatf("t5_dbg%0d", i), {16'h0000, a_dbg_data},
                  (i < 3) ? 32'h0 : 32'(16 + 3 * ((i / 3) - 1)));
            if (a_ready) acc++;
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rd(1'b1, 8, v);
        check("t5_final_r8", v, 32'h0019);
        check("t5_accepts", 32'(acc), 32'd4);

        // Wide instance: LSH and LUI leave flags alone
        issue(1'b0, 4'd0, 1'b1, 1, 0, 8'h00);
        check("b_add0_flags", b_flags, 32'h08);
        issue(1'b0, 4'd7, 1'b1, 31, 0, 8'h01);
        issue(1'b0, 4'd8, 1'b1, 31, 0, 8'h1F);
        rd(1'b0, 31, v);
        check("b_lsh31", v, 32'h8000_0000);
        check("b_lsh_flags", b_flags, 32'h08);
        issue(1'b0, 4'd9, 1'b1, 0, 0, 8'hAB);
        rd(1'b0, 0, v);
        check("b_lui", v, 32'h0000_AB00);
        check("b_lui_result", b_result, 32'h0000_AB00);
        check("b_lui_flags", b_flags, 32'h08);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
